// File: rtl/uart_tx_frame_loader_pkg.sv
// Shared types and frame assembly for the UART TX frame loader.
// A frame is start, 7/8 data bits LSB-first, optional parity, 1/2 stop bits, padded with ones.
package uart_tx_frame_loader_pkg;

   localparam int unsigned FrameW = 12;

   localparam logic [1:0] ParNone = 2'b00;
   localparam logic [1:0] ParOdd  = 2'b01;
   localparam logic [1:0] ParEven = 2'b10;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StSend,
      StGap
   } state_e;

   function automatic logic [FrameW-1:0] build_frame(input logic [7:0] data,
                                                     input logic       data_length,
                                                     input logic       stop_bits,
                                                     input logic [1:0] parity_type);
      logic [FrameW-1:0] frame;
      logic              par;
      logic [3:0]        pos;
      frame    = '1;
      frame[0] = 1'b0;
      if (data_length) begin
         frame[8:1] = data;
         par        = ^data;
         pos        = 4'd9;
      end else begin
         frame[7:1] = data[6:0];
         par        = ^data[6:0];
         pos        = 4'd8;
      end
      if (parity_type == ParOdd) begin
         par = ~par;
      end
      if ((parity_type == ParOdd) || (parity_type == ParEven)) begin
         frame[pos] = par;
         pos        = pos + 4'd1;
      end
      frame[pos] = 1'b1;
      if (stop_bits) begin
         frame[pos + 4'd1] = 1'b1;
      end
      return frame;
   endfunction

endpackage

// File: rtl/uart_tx_frame_loader_fifo.sv
// Synchronous FIFO holding host bytes; a push into a full FIFO is accepted only alongside a pop.
module uart_tx_frame_loader_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned AddrW  = $clog2(DEPTH);
   localparam int unsigned LevelW = AddrW + 1;

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LevelW-1:0] level_q, level_d;
   logic              do_push, do_pop;

   assign full_o    = (level_q == LevelW'(DEPTH));
   assign empty_o   = (level_q == '0);
   assign level_o   = level_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

endmodule

// File: rtl/uart_tx_frame_loader.sv
// Feeds the UART TX shifter: buffers host bytes, builds each frame and runs the send handshake,
// waiting for the shifter's tx_done (baud domain) before moving on.
module uart_tx_frame_loader
   import uart_tx_frame_loader_pkg::*;
#(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned LOAD_TICKS = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   wr_en_i,
   input  logic [7:0]             wr_data_i,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   overflow_o,
   input  logic                   clr_ovf_i,
   input  logic                   data_length_i,
   input  logic                   stop_bits_i,
   input  logic [1:0]             parity_type_i,
   input  logic                   baud_tick_i,
   input  logic                   tx_done_i,
   output logic [FrameW-1:0]      frame_out_o,
   output logic                   send_o,
   output logic                   busy_o
);

   localparam int unsigned TickW = $clog2(LOAD_TICKS);

   state_e            state_q, state_d;
   logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
   logic [FrameW-1:0] frame_q, frame_d;
   logic              send_q;
   logic              overflow_q, overflow_d;
   logic              done_s1_q, done_s2_q, done_prev_q, done_p;
   logic              fifo_pop;
   logic [7:0]        fifo_data;
   logic              drop;

   uart_tx_frame_loader_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (wr_en_i),
      .wr_data_i (wr_data_i),
      .pop_i     (fifo_pop),
      .rd_data_o (fifo_data),
      .full_o    (full_o),
      .empty_o   (empty_o),
      .level_o   (level_o)
   );

   assign drop       = wr_en_i && full_o && !fifo_pop;
   // A drop in the same cycle as a clear wins so no lost byte goes unreported.
   assign overflow_d = drop ? 1'b1 : (clr_ovf_i ? 1'b0 : overflow_q);
   assign done_p     = done_s2_q && !done_prev_q;

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      frame_d    = frame_q;
      fifo_pop   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty_o) begin
               state_d    = StLoad;
               fifo_pop   = 1'b1;
               tick_cnt_d = '0;
               frame_d    = build_frame(fifo_data, data_length_i, stop_bits_i, parity_type_i);
            end
         end
         StLoad: begin
            if (baud_tick_i) begin
               if (tick_cnt_q == TickW'(LOAD_TICKS - 1)) begin
                  state_d    = StSend;
                  tick_cnt_d = '0;
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         StSend: begin
            if (done_p) begin
               state_d = StGap;
            end
         end
         StGap: begin
            if (baud_tick_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         tick_cnt_q  <= '0;
         frame_q     <= '1;
         send_q      <= 1'b0;
         overflow_q  <= 1'b0;
         done_s1_q   <= 1'b0;
         done_s2_q   <= 1'b0;
         done_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         frame_q     <= frame_d;
         send_q      <= (state_d == StSend);
         overflow_q  <= overflow_d;
         done_s1_q   <= tx_done_i;
         done_s2_q   <= done_s1_q;
         done_prev_q <= done_s2_q;
      end
   end

   assign frame_out_o = frame_q;
   assign send_o      = send_q;
   assign busy_o      = (state_q != StIdle);
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_uart_tx_frame_loader.sv
// Directed bench for uart_tx_frame_loader with hand-computed frames and handshake timing.
module tb_uart_tx_frame_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_data = 8'h00;
   logic        full, empty, overflow;
   logic [3:0]  level;
   logic        clr_ovf = 1'b0;
   logic        data_length = 1'b1;
   logic        stop_bits = 1'b0;
   logic [1:0]  parity_type = 2'b00;
   logic        baud_tick = 1'b0;
   logic        tx_done = 1'b0;
   logic [11:0] frame_out;
   logic        send, busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   uart_tx_frame_loader #(
      .DEPTH      (8),
      .LOAD_TICKS (2)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .wr_en_i       (wr_en),
      .wr_data_i     (wr_data),
      .full_o        (full),
      .empty_o       (empty),
      .level_o       (level),
      .overflow_o    (overflow),
      .clr_ovf_i     (clr_ovf),
      .data_length_i (data_length),
      .stop_bits_i   (stop_bits),
      .parity_type_i (parity_type),
      .baud_tick_i   (baud_tick),
      .tx_done_i     (tx_done),
      .frame_out_o   (frame_out),
      .send_o        (send),
      .busy_o        (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] d);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
   endtask

   task automatic cfg(input logic dl, input logic sb, input logic [1:0] pt);
      data_length = dl;
      stop_bits   = sb;
      parity_type = pt;
   endtask

   // Raise tx_done, expect GAP after the synchroniser, then one baud tick back to IDLE.
   task automatic done_frame(input string tag);
      tx_done = 1'b1;
      cyc(3);
      chk({tag, "_gap_send"}, 32'(send), 32'd0);
      chk({tag, "_gap_busy"}, 32'(busy), 32'd1);
      tx_done = 1'b0;
      cyc(3);
      tick();
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   logic [11:0] exp_b2b [3];

   initial begin
      // 1: reset with a push held high
      wr_en   = 1'b1;
      wr_data = 8'h77;
      cyc(3);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_send", 32'(send), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame", 32'(frame_out), 32'hFFF);
      chk("rst_ovf", 32'(overflow), 32'd0);
      wr_en = 1'b0;
      rst   = 1'b0;
      cyc(2);
      chk("post_rst_empty", 32'(empty), 32'd1);

      // 2: 8 data bits, even parity, one stop, 0xA5
      cfg(1'b1, 1'b0, 2'b10);
      push(8'hA5);
      chk("t2_level", 32'(level), 32'd1);
      cyc(1);
      chk("t2_frame", 32'(frame_out), 32'hD4A);
      chk("t2_busy", 32'(busy), 32'd1);
      chk("t2_popped", 32'(level), 32'd0);
      tick();
      chk("t2_send_tick1", 32'(send), 32'd0);
      tick();
      chk("t2_send_tick2", 32'(send), 32'd1);
      done_frame("t2");
      chk("t2_frame_hold", 32'(frame_out), 32'hD4A);

      // 3: 7 data bits, odd parity, two stops, 0x03; config change and stale done ignored
      cfg(1'b0, 1'b1, 2'b01);
      push(8'h03);
      cyc(1);
      chk("t3_frame", 32'(frame_out), 32'hF06);
      cfg(1'b1, 1'b0, 2'b10);
      tx_done = 1'b1;
      cyc(4);
      tick();
      tick();
      chk("t3_send", 32'(send), 32'd1);
      cyc(4);
      chk("t3_stale_done", 32'(send), 32'd1);
      chk("t3_frame_held", 32'(frame_out), 32'hF06);
      tx_done = 1'b0;
      cyc(3);
      done_frame("t3");

      // 4: three bytes back-to-back, no parity
      cfg(1'b1, 1'b0, 2'b00);
      exp_b2b[0] = 12'hE22;
      exp_b2b[1] = 12'hE44;
      exp_b2b[2] = 12'hE66;
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'h11;
      @(negedge clk);
      wr_data = 8'h22;
      @(negedge clk);
      wr_data = 8'h33;
      @(negedge clk);
      wr_en = 1'b0;
      chk("t4_level", 32'(level), 32'd2);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("t4_frame%0d", k), 32'(frame_out), 32'(exp_b2b[k]));
         chk($sformatf("t4_busy%0d", k), 32'(busy), 32'd1);
         tick();
         tick();
         chk($sformatf("t4_send%0d", k), 32'(send), 32'd1);
         done_frame($sformatf("t4_f%0d", k));
         cyc(1);
      end
      chk("t4_drained", 32'(busy), 32'd0);
      chk("t4_empty", 32'(empty), 32'd1);

      // 5: hold one frame in LOAD, then overfill the FIFO
      cfg(1'b1, 1'b0, 2'b10);
      push(8'h80);
      cyc(1);
      chk("t5_frame0", 32'(frame_out), 32'hF00);
      for (int i = 1; i <= 8; i++) begin
         push(8'(8'h80 + i));
      end
      chk("t5_full", 32'(full), 32'd1);
      chk("t5_level8", 32'(level), 32'd8);
      chk("t5_no_ovf", 32'(overflow), 32'd0);
      push(8'h89);
      chk("t5_ovf", 32'(overflow), 32'd1);
      chk("t5_level_drop", 32'(level), 32'd8);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'h8A;
      clr_ovf = 1'b1;
      @(negedge clk);
      wr_en   = 1'b0;
      clr_ovf = 1'b0;
      chk("t5_clr_and_drop", 32'(overflow), 32'd1);
      @(negedge clk);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      chk("t5_clr", 32'(overflow), 32'd0);
      chk("t5_level_kept", 32'(level), 32'd8);
      chk("t5_full_kept", 32'(full), 32'd1);
      tick();
      tick();
      done_frame("t5");
      cyc(1);
      chk("t5_frame1", 32'(frame_out), 32'hD02);
      chk("t5_level7", 32'(level), 32'd7);

      // 6: reset during SEND, then a fresh byte
      tick();
      tick();
      chk("t6_send", 32'(send), 32'd1);
      rst = 1'b1;
      cyc(1);
      chk("t6_rst_send", 32'(send), 32'd0);
      chk("t6_rst_empty", 32'(empty), 32'd1);
      chk("t6_rst_level", 32'(level), 32'd0);
      chk("t6_rst_frame", 32'(frame_out), 32'hFFF);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      cyc(1);
      push(8'h5A);
      cyc(1);
      chk("t6_frame", 32'(frame_out), 32'hCB4);
      tick();
      tick();
      chk("t6_send_after", 32'(send), 32'd1);
      done_frame("t6");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
